// File: rtl/modulo_controle_jogo.sv
// Naval-battle game sequencer: button debounce, placement/attack phase control,
// attack cursor, shot evaluation against the position matrix, and win/loss tracking.
module modulo_controle_jogo #(
    parameter int DEB_CYCLES = 50000,
    parameter int HIT_TARGET = 9,
    parameter int MAX_SHOTS  = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        button_count,
    input  logic        button_confirmation,
    input  logic [1:0]  mode,
    input  logic [34:0] m_po,
    output logic        po_load,
    output logic [34:0] m_at,
    output logic [34:0] m_hit,
    output logic [2:0]  cursor_row,
    output logic [2:0]  cursor_col,
    output logic [1:0]  status,
    output logic [4:0]  shots,
    output logic [3:0]  hits,
    output logic        game_over,
    output logic        win
);
    // state  | meaning
    // IDLE   | mode 00: board and counters held cleared
    // PLACE  | ship placement; confirm pulses po_load
    // AIM    | cursor moves on count, confirm fires a shot
    // CHECK  | evaluate the latched cell, update matrices/counters
    // RESULT | decide win, loss or keep aiming
    // OVER   | game ended; buttons ignored until mode 00
    typedef enum logic [2:0] {S_IDLE, S_PLACE, S_AIM, S_CHECK, S_RESULT, S_OVER} state_t;

    localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD = DEB_W'(DEB_CYCLES - 1);
    localparam logic [3:0]        HIT_MAX  = 4'(HIT_TARGET);
    localparam logic [4:0]        SHOT_MAX = 5'(MAX_SHOTS);

    // index 0 = count button, index 1 = confirm button
    logic [1:0]            sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
    logic [1:0][DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = DEB_LOAD;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == '0) deb_d[i] = sync2_q[i];
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        press_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            deb_q   <= 2'b11;
            cnt_q   <= {2{DEB_LOAD}};
            press_q <= 2'b00;
        end else begin
            sync1_q <= {button_confirmation, button_count};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    state_t      state_q, state_d;
    logic [34:0] m_at_q, m_at_d, m_hit_q, m_hit_d;
    logic [2:0]  row_q, row_d, col_q, col_d;
    logic [1:0]  status_q, status_d;
    logic [4:0]  shots_q, shots_d;
    logic [3:0]  hits_q, hits_d;
    logic [5:0]  shot_idx_q, shot_idx_d;
    logic        po_load_q, po_load_d, game_over_q, game_over_d, win_q, win_d;
    logic [5:0]  cur_bit;
    logic        pulse_cnt, pulse_conf;

    assign pulse_conf = press_q[1];
    assign pulse_cnt  = press_q[0] & ~press_q[1];
    assign cur_bit    = 6'd34 - (6'd5 * {3'b000, row_q} + {3'b000, col_q});

    always_comb begin
        state_d     = state_q;
        m_at_d      = m_at_q;
        m_hit_d     = m_hit_q;
        row_d       = row_q;
        col_d       = col_q;
        status_d    = status_q;
        shots_d     = shots_q;
        hits_d      = hits_q;
        shot_idx_d  = shot_idx_q;
        game_over_d = game_over_q;
        win_d       = win_q;
        po_load_d   = 1'b0;

        if (state_q == S_IDLE) begin
            m_at_d      = '0;
            m_hit_d     = '0;
            row_d       = '0;
            col_d       = '0;
            status_d    = '0;
            shots_d     = '0;
            hits_d      = '0;
            game_over_d = 1'b0;
            win_d       = 1'b0;
        end

        // mode 00 aborts from anywhere, including mid-shot
        if (mode == 2'b00) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode == 2'b01)      state_d = S_PLACE;
                    else if (mode == 2'b10) state_d = S_AIM;
                end
                S_PLACE: begin
                    if (mode == 2'b10)                    state_d = S_AIM;
                    else if (mode == 2'b01 && pulse_conf) po_load_d = 1'b1;
                end
                S_AIM: begin
                    if (mode == 2'b01) begin
                        state_d = S_PLACE;
                    end else if (mode == 2'b10) begin
                        if (pulse_conf) begin
                            shot_idx_d = cur_bit;
                            state_d    = S_CHECK;
                        end else if (pulse_cnt) begin
                            if (row_q == 3'd6) begin
                                row_d = 3'd0;
                                col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
                            end else begin
                                row_d = row_q + 3'd1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (m_at_q[shot_idx_q]) begin
                        status_d = 2'b11;
                    end else begin
                        m_at_d[shot_idx_q] = 1'b1;
                        shots_d = (shots_q == SHOT_MAX) ? shots_q : shots_q + 5'd1;
                        if (m_po[shot_idx_q]) begin
                            m_hit_d[shot_idx_q] = 1'b1;
                            hits_d   = (hits_q == HIT_MAX) ? hits_q : hits_q + 4'd1;
                            status_d = 2'b10;
                        end else begin
                            status_d = 2'b01;
                        end
                    end
                    state_d = S_RESULT;
                end
                S_RESULT: begin
                    if (hits_q == HIT_MAX) begin
                        game_over_d = 1'b1;
                        win_d       = 1'b1;
                        state_d     = S_OVER;
                    end else if (shots_q == SHOT_MAX) begin
                        game_over_d = 1'b1;
                        win_d       = 1'b0;
                        state_d     = S_OVER;
                    end else begin
                        state_d = S_AIM;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            m_at_q      <= '0;
            m_hit_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            status_q    <= '0;
            shots_q     <= '0;
            hits_q      <= '0;
            shot_idx_q  <= '0;
            po_load_q   <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_at_q      <= m_at_d;
            m_hit_q     <= m_hit_d;
            row_q       <= row_d;
            col_q       <= col_d;
            status_q    <= status_d;
            shots_q     <= shots_d;
            hits_q      <= hits_d;
            shot_idx_q  <= shot_idx_d;
            po_load_q   <= po_load_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

    assign po_load    = po_load_q;
    assign m_at       = m_at_q;
    assign m_hit      = m_hit_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign status     = status_q;
    assign shots      = shots_q;
    assign hits       = hits_q;
    assign game_over  = game_over_q;
    assign win        = win_q;
endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Directed bench for modulo_controle_jogo: two instances share stimulus, one with a
// 20-shot budget (cursor, miss/repeat, win) and one with a 3-shot budget (loss).
module tb_modulo_controle_jogo;
    logic        clk = 1'b0;
    logic        clr;
    logic        btn_cnt, btn_conf;
    logic [1:0]  mode;
    logic [34:0] m_po;

    logic        a_po_load, a_game_over, a_win;
    logic [34:0] a_m_at, a_m_hit;
    logic [2:0]  a_row, a_col;
    logic [1:0]  a_status;
    logic [4:0]  a_shots;
    logic [3:0]  a_hits;

    logic        b_po_load, b_game_over, b_win;
    logic [34:0] b_m_at, b_m_hit;
    logic [2:0]  b_row, b_col;
    logic [1:0]  b_status;
    logic [4:0]  b_shots;
    logic [3:0]  b_hits;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    modulo_controle_jogo #(.DEB_CYCLES(4), .HIT_TARGET(9), .MAX_SHOTS(20)) dut_a (
        .clk(clk), .clr(clr), .button_count(btn_cnt), .button_confirmation(btn_conf),
        .mode(mode), .m_po(m_po), .po_load(a_po_load), .m_at(a_m_at), .m_hit(a_m_hit),
        .cursor_row(a_row), .cursor_col(a_col), .status(a_status), .shots(a_shots),
        .hits(a_hits), .game_over(a_game_over), .win(a_win)
    );

    modulo_controle_jogo #(.DEB_CYCLES(4), .HIT_TARGET(9), .MAX_SHOTS(3)) dut_b (
        .clk(clk), .clr(clr), .button_count(btn_cnt), .button_confirmation(btn_conf),
        .mode(mode), .m_po(m_po), .po_load(b_po_load), .m_at(b_m_at), .m_hit(b_m_hit),
        .cursor_row(b_row), .cursor_col(b_col), .status(b_status), .shots(b_shots),
        .hits(b_hits), .game_over(b_game_over), .win(b_win)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_cnt();
        btn_cnt = 1'b0; cyc(10);
        btn_cnt = 1'b1; cyc(10);
    endtask

    task automatic press_conf();
        btn_conf = 1'b0; cyc(10);
        btn_conf = 1'b1; cyc(10);
    endtask

    initial begin
        clr = 1'b1; btn_cnt = 1'b1; btn_conf = 1'b1; mode = 2'b00; m_po = '0;
        cyc(3);
        chk("rst_shots",   64'(a_shots), 64'(0));
        chk("rst_status",  64'(a_status), 64'(0));
        chk("rst_m_at",    64'(a_m_at), 64'(0));
        chk("rst_cursor",  64'({a_row, a_col}), 64'(0));
        chk("rst_over",    64'({a_game_over, a_win, a_po_load, b_po_load}), 64'(0));
        clr = 1'b0;
        cyc(2);

        // bouncing count button: only the final steady low is accepted
        mode = 2'b10; cyc(2);
        for (int i = 0; i < 10; i++) begin
            btn_cnt = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        btn_cnt = 1'b0; cyc(10);
        btn_cnt = 1'b1; cyc(10);
        chk("deb_row", 64'(a_row), 64'(1));
        chk("deb_col", 64'(a_col), 64'(0));

        // cursor wrap
        mode = 2'b00; cyc(2);
        chk("idle_cursor", 64'({a_row, a_col}), 64'(0));
        mode = 2'b10; cyc(2);
        for (int k = 1; k <= 35; k++) begin
            press_cnt();
            if (k == 7)  chk("wrap_k7",  64'({a_row, a_col}), 64'({3'd0, 3'd1}));
            if (k == 34) chk("wrap_k34", 64'({a_row, a_col}), 64'({3'd6, 3'd4}));
            if (k == 35) chk("wrap_k35", 64'({a_row, a_col}), 64'({3'd0, 3'd0}));
        end

        // miss then repeat at (0,0)
        press_conf();
        chk("miss_status", 64'(a_status), 64'(1));
        chk("miss_shots",  64'(a_shots), 64'(1));
        chk("miss_m_at",   64'(a_m_at), 64'(35'h400000000));
        chk("miss_hits",   64'(a_hits), 64'(0));
        press_conf();
        chk("rep_status", 64'(a_status), 64'(3));
        chk("rep_shots",  64'(a_shots), 64'(1));
        chk("rep_m_at",   64'(a_m_at), 64'(35'h400000000));

        // win: ships on cursor steps 0..8 -> (0..6,0),(0,1),(1,1)
        mode = 2'b00; cyc(2);
        m_po = 35'h631084210;
        mode = 2'b10; cyc(2);
        for (int i = 0; i < 9; i++) begin
            press_conf();
            if (i == 0) begin
                chk("win_first_status", 64'(a_status), 64'(2));
                chk("win_first_hits",   64'(a_hits), 64'(1));
            end
            if (i == 7) chk("win_not_yet", 64'(a_game_over), 64'(0));
            if (i < 8) press_cnt();
        end
        chk("win_hits",  64'(a_hits), 64'(9));
        chk("win_shots", 64'(a_shots), 64'(9));
        chk("win_flags", 64'({a_game_over, a_win}), 64'(2'b11));
        chk("win_m_hit", 64'(a_m_hit), 64'(35'h631084210));
        chk("win_m_at",  64'(a_m_at), 64'(35'h631084210));
        press_conf();
        press_cnt();
        chk("over_shots",  64'(a_shots), 64'(9));
        chk("over_cursor", 64'({a_row, a_col}), 64'({3'd1, 3'd1}));

        // loss on the 3-shot instance, with a simultaneous press in the middle
        mode = 2'b00; cyc(2);
        m_po = '0;
        mode = 2'b10; cyc(2);
        press_conf();
        chk("loss_shot1", 64'({b_shots, b_status}), 64'({5'd1, 2'd1}));
        press_cnt();
        btn_cnt = 1'b0; btn_conf = 1'b0; cyc(10);
        btn_cnt = 1'b1; btn_conf = 1'b1; cyc(10);
        chk("simul_shots", 64'(b_shots), 64'(2));
        chk("simul_row",   64'(b_row), 64'(1));
        chk("simul_m_at",  64'(b_m_at), 64'(35'h420000000));
        press_cnt();
        btn_conf = 1'b0; cyc(8);
        chk("loss_n2_shots", 64'(b_shots), 64'(3));
        chk("loss_n2_over",  64'(b_game_over), 64'(0));
        cyc(1);
        chk("loss_n3_flags", 64'({b_game_over, b_win}), 64'(2'b10));
        cyc(1);
        btn_conf = 1'b1; cyc(10);
        press_cnt();
        chk("loss_over_cursor", 64'({b_row, b_col}), 64'({3'd2, 3'd0}));
        mode = 2'b00; cyc(2);
        chk("clear_counts", 64'({b_shots, b_hits, b_status}), 64'(0));
        chk("clear_m_at",   64'(b_m_at), 64'(0));
        chk("clear_m_hit",  64'(a_m_hit), 64'(0));
        chk("clear_flags",  64'({b_game_over, b_win, b_row, b_col}), 64'(0));

        // placement strobe timing
        mode = 2'b01; cyc(2);
        btn_conf = 1'b0; cyc(6);
        chk("po_load_pre",  64'(a_po_load), 64'(0));
        cyc(1);
        chk("po_load_on",   64'(a_po_load), 64'(1));
        cyc(1);
        chk("po_load_off",  64'(a_po_load), 64'(0));
        btn_conf = 1'b1; cyc(10);

        // freeze
        mode = 2'b10; cyc(2);
        press_cnt();
        chk("pre_freeze_row", 64'(a_row), 64'(1));
        mode = 2'b11; cyc(2);
        press_cnt();
        press_conf();
        chk("freeze_cursor", 64'({a_row, a_col}), 64'({3'd1, 3'd0}));
        chk("freeze_shots",  64'({a_shots, a_status}), 64'(0));
        mode = 2'b10; cyc(2);
        press_cnt();
        chk("resume_row", 64'(a_row), 64'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/modulo_controle_jogo.md
# modulo_controle_jogo

Game sequencer for the naval-battle board. It debounces the two player buttons, drives the placement and attack phases from the 2-bit mode switch, and moves the attack cursor over the 7×5 board. On each shot it checks the stored position matrix and keeps the attack/hit matrices, shot and hit counters and result status. It sits between the board switches/buttons and the matrix-display and 7-segment paths, and replaces the loose counter/demux control around the attack register bank.

## Interface
- DEB_CYCLES, 50000: clock cycles a button level must stay stable before it is accepted.
- HIT_TARGET, 9: number of occupied cells; reaching this many hits wins.
- MAX_SHOTS, 20: shot budget; reaching it without winning loses.
- clk  in  1  system clock.
- clr  in  1  reset, asynchronous, active-high.
- button_count  in  1  raw cursor-advance button, active-low.
- button_confirmation  in  1  raw confirm button, active-low.
- mode  in  2  phase switch: 00 reset/idle, 01 placement, 10 attack, 11 view (freeze).
- m_po  in  35  position matrix; bit 34−(5·row+col) = 1 means ship at (row 0–6, col 0–4).
- po_load  out  1  one-cycle strobe telling the position register to capture its preset.
- m_at  out  35  attacked-cell matrix, same indexing as m_po.
- m_hit  out  35  hit-cell matrix, same indexing.
- cursor_row  out  3  cursor row, 0–6.
- cursor_col  out  3  cursor column, 0–4.
- status  out  2  last shot: 00 none, 01 water, 10 hit, 11 repeated cell.
- shots  out  5  shots fired.
- hits  out  4  hits scored.
- game_over  out  1  game ended.
- win  out  1  valid with game_over: 1 = all ships sunk.

## Operation
- Buttons: each goes through a 2-flop synchronizer, then a stability counter. The debounced level updates only after DEB_CYCLES identical samples. A 1→0 transition of the debounced level gives a one-cycle press pulse.
- FSM states: IDLE, PLACE, AIM, CHECK, RESULT, OVER.
- Any state with mode=00 → IDLE next cycle. IDLE synchronously clears m_at, m_hit, shots, hits, status, cursor, game_over and win.
- IDLE/AIM with mode=01 → PLACE. In PLACE, a confirm press pulses po_load and the FSM stays in PLACE.
- IDLE/PLACE with mode=10 → AIM.
- Mode 11 in any non-IDLE state holds all registers (state retained). Returning to 10 resumes.
- AIM, count press: advance the cursor. row+1; row 6 wraps to 0 with col+1; (6,4) wraps to (0,0).
- AIM, confirm press → CHECK, latching the cursor index. Cursor-advance presses are ignored until back in AIM.
- Simultaneous count and confirm pulses: confirm wins and the count press is dropped.
- CHECK → RESULT:
  - Cell already set in m_at: status=11; shots, hits and matrices are unchanged.
  - Otherwise: set the m_at bit and shots+1. If the m_po bit is 1, set the m_hit bit, hits+1 and status=10; else status=01.
- RESULT:
  - hits==HIT_TARGET → OVER with win=1, game_over=1.
  - Otherwise shots==MAX_SHOTS → OVER with win=0, game_over=1.
  - Otherwise → AIM.
- OVER ignores both buttons. Only mode=00 or clr leaves it.
- Counters saturate: shots at MAX_SHOTS, hits at HIT_TARGET.

## Timing
- Reset (clr=1, asynchronous): FSM=IDLE, all outputs 0, and debounced levels = 1 (released).
- Press detection latency: button edge to press pulse = 2 sync cycles + DEB_CYCLES.
- Cursor update: registered on the cycle after the count pulse.
- Shot latency: confirm pulse at cycle N → CHECK at N+1 → m_at/m_hit/shots/hits/status valid at N+2 → game_over valid at N+3.
- po_load: high for exactly the cycle after the confirm pulse in PLACE.
- Mode is sampled every cycle without synchronization; the switch is assumed slow. A mode change during CHECK/RESULT completes the shot before the state change takes effect, except mode=00, which aborts immediately.
- clr asserted mid-shot: everything is cleared immediately, and no partial matrix write survives.

## Test plan
- Reset/debounce (DEB_CYCLES=4): pulse clr, then bounce button_count low/high every 2 cycles for 20 cycles, then hold low 10 cycles → exactly one cursor step, to (1,0).
- Cursor wrap: 34 count presses from (0,0) → (6,4); one more press → (0,0).
- Miss then repeat: m_po all 0, mode=10, confirm at (0,0) → status=01, shots=1, m_at[34]=1. Confirm again at (0,0) → status=11, shots=1.
- Win: m_po with 9 bits set, HIT_TARGET=9, shoot the nine cells → hits=9, game_over=1, win=1. Further presses do not change shots.
- Loss: MAX_SHOTS=3, three misses → shots=3, game_over=1, win=0 at N+3 of the third confirm. Then mode=00 → all counters and matrices 0.
- Placement/freeze: mode=01 plus confirm → po_load high for one cycle. Mode=11 plus presses → cursor and counters unchanged.
